uart_tx_multi: RTL
==================

Name: uart_tx_multi

Overview:
- Next-generation UART transmitter with an integrated TX FIFO.
- Data length, parity mode and stop-bit count are selectable at run time.
- Paced by the existing uart_baudgen through the i_baud / o_baud_en handshake, the same way uart_tx is.
- Sits between a host write interface and the TX pin; data is sent LSB first.

Parameters:
MAX_DATA_WIDTH, 9, widest character supported; i_din width; legal range 5..9
FIFO_DEPTH, 16, TX FIFO entries; power of two, >=2
LEN_W, $clog2(MAX_DATA_WIDTH+1), width of i_data_len (derived, not overridden)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_baud  in  1  one-cycle bit-period tick from uart_baudgen
o_baud_en  out  1  enables uart_baudgen; baudgen restarts its count while low
i_data_len  in  LEN_W  data bits per frame, 5..MAX_DATA_WIDTH; <5 treated as 5, >MAX treated as MAX
i_parity_mode  in  2  00 none, 01 odd, 10 even, 11 mark (parity bit = 1)
i_stop2  in  1  0: one stop bit, 1: two stop bits
i_din  in  MAX_DATA_WIDTH  write data; only the low i_data_len bits are sent
i_valid  in  1  write strobe
o_ready  out  1  FIFO not full
o_overflow  out  1  one-cycle pulse when i_valid && !o_ready (write dropped)
o_fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
o_busy  out  1  FIFO non-empty or frame in progress
o_TX  out  1  serial line, idle high

Behaviour:
- One clock domain, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: o_TX=1, o_baud_en=0, o_busy=0, o_ready=1, o_overflow=0, o_fifo_count=0, FSM=IDLE.
- A reset mid-frame aborts the frame and flushes the FIFO; o_TX is 1 on the next cycle.
- FIFO writes: push when i_valid && o_ready. Writes while full are dropped and pulse o_overflow.
- FIFO push and pop in the same cycle: count unchanged. While full, a pop raises o_ready on the next cycle.
- o_TX, o_baud_en and o_busy are registered. o_ready and o_fifo_count come from registered state.
- FSM states: IDLE, START, DATA, PARITY, STOP. All non-IDLE states advance only on i_baud.
- IDLE:
  - o_TX=1, o_baud_en=0.
  - If FIFO non-empty (and the CTS gate allows), pop the head.
  - Latch shift register, len, parity mode and stop2. Config changes mid-frame have no effect.
  - Go to START; on the next cycle o_TX=0 and o_baud_en=1.
- START: on i_baud go to DATA with bit_cnt=0.
- DATA:
  - o_TX = shift[0].
  - On i_baud: shift right, bit_cnt++.
  - When bit_cnt == len-1: go to PARITY if mode != 00, else STOP.
- PARITY:
  - Parity is computed over the len bits only; higher bits are ignored.
  - Odd: total count of ones (data + parity) is odd. Even: total is even. Mark: parity bit = 1.
  - On i_baud go to STOP.
- STOP:
  - o_TX=1.
  - On i_baud: if stop2 and this is the first stop bit, stay for a second bit; else go to IDLE.
- Back-to-back frames: exactly one i_clk of idle line between the last stop bit and the next start bit.
- Frame length in baud periods = 1 + len + (mode!=00) + 1 + stop2.
- o_baud_en rises with the start bit, so each bit lasts exactly one baudgen period.
- o_busy = (FSM != IDLE) || FIFO non-empty.

Optional Feature:
- Macro UART_TX_CTS_EN.
- Defined:
  - Adds input i_cts_n (active-low clear-to-send, asynchronous).
  - i_cts_n passes through a 2-flop synchronizer.
  - IDLE pops and starts a frame only when the synchronized cts_n == 0.
  - Deassertion mid-frame does not abort; it blocks the next frame.
  - o_busy stays high while data waits.
- Undefined: port absent; frames start whenever the FIFO is non-empty.

Test Plan:
- 25 MHz clock, baudgen divisor 217 (115200 baud).
- Reference receiver configured to match the DUT settings.
1. len=8, parity none, stop2=0, write 0xA6 -> RX gets 0xA6. Frame = 10 bit periods (~2170 clk). o_busy falls 1 clk after the stop bit.
2. len=7, odd parity, write 0x137 -> line carries bits 0x37 LSB first, then parity=0 (five ones in 0x37 plus parity bit 0 gives odd total). Bit 7 is not sent.
3. len=9, even parity, stop2=1, write 0x1FF -> 9 ones then parity=1, then two stop bits. Frame = 13 bit periods.
4. Write 17 words (0x00..0x10) in consecutive cycles with FIFO_DEPTH=16.
   - Expect o_ready low after the 16th accepted write (or the 17th if a pop has already started), with o_overflow pulsing on any dropped write.
   - Every accepted word is received in order, with a 1-clk gap between frames.
5. Assert i_rst during the DATA state of a frame with 3 words queued -> o_TX=1 next cycle, o_fifo_count=0, o_busy=0. No further frames are sent.
6. UART_TX_CTS_EN defined:
   - Hold i_cts_n=1 and write 0x55 -> no start bit, o_busy=1.
   - Drop i_cts_n=0 -> start bit within 3 clk, RX gets 0x55.
   - Raise i_cts_n mid-frame -> the frame completes.

Source files
------------

// File: rtl/uart_tx_multi.sv
// uart_tx_multi: UART transmitter with TX FIFO and run-time length/parity/stop configuration.
// Ports: i_clk/i_rst (sync, active-high); i_baud tick from uart_baudgen, o_baud_en enables it;
// i_data_len/i_parity_mode/i_stop2 frame config (latched at frame start); i_din/i_valid host write,
// o_ready (FIFO not full), o_overflow (dropped write), o_fifo_count; o_busy; o_TX serial line.
// Optional macro UART_TX_CTS_EN adds i_cts_n (async, active-low) gating frame starts.
module uart_tx_multi #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W = $clog2(MAX_DATA_WIDTH + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_baud,
  output logic                        o_baud_en,
  input  logic [LEN_W-1:0]            i_data_len,
  input  logic [1:0]                  i_parity_mode,
  input  logic                        i_stop2,
  input  logic [MAX_DATA_WIDTH-1:0]   i_din,
  input  logic                        i_valid,
`ifdef UART_TX_CTS_EN
  input  logic                        i_cts_n,
`endif
  output logic                        o_ready,
  output logic                        o_overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_busy,
  output logic                        o_TX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [MAX_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic push, pop, cts_ok;
  logic [MAX_DATA_WIDTH-1:0] head, mask, shift, shift_n;
  logic [LEN_W-1:0] len_c, len, len_n, bit_cnt, bit_cnt_n;
  logic par, par_n, has_par, has_par_n, stop2, stop2_n, stop_cnt, stop_cnt_n, tx_n;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;
  always_ff @(posedge i_clk)
    cts_sync <= i_rst ? 2'b11 : {cts_sync[0], i_cts_n};
  assign cts_ok = !cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign o_ready = count != CW'(FIFO_DEPTH);
  assign o_overflow = i_valid && !o_ready;
  assign o_fifo_count = count;
  assign push = i_valid && o_ready;
  assign pop = state == IDLE && count != '0 && cts_ok;
  assign count_n = count + CW'(push) - CW'(pop);
  assign head = mem[rd_ptr];
  // out-of-range lengths are clamped into 5..MAX_DATA_WIDTH
  assign len_c = i_data_len < LEN_W'(5) ? LEN_W'(5)
               : i_data_len > LEN_W'(MAX_DATA_WIDTH) ? LEN_W'(MAX_DATA_WIDTH) : i_data_len;
  assign mask = MAX_DATA_WIDTH'((1 << len_c) - 1);

  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= i_din;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count_n;
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    len_n      = len;
    bit_cnt_n  = bit_cnt;
    par_n      = par;
    has_par_n  = has_par;
    stop2_n    = stop2;
    stop_cnt_n = stop_cnt;
    case (state)
      IDLE: if (pop) begin
        state_n    = START;
        shift_n    = head & mask;
        len_n      = len_c;
        // odd parity inverts the data XOR; mark forces 1
        par_n      = (&i_parity_mode) | (^(head & mask) ^ (i_parity_mode == 2'b01));
        has_par_n  = |i_parity_mode;
        stop2_n    = i_stop2;
        bit_cnt_n  = '0;
        stop_cnt_n = 1'b0;
      end
      START: if (i_baud) begin
        state_n   = DATA;
        bit_cnt_n = '0;
      end
      DATA: if (i_baud) begin
        shift_n   = shift >> 1;
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == len - LEN_W'(1)) state_n = has_par ? PARITY : STOP;
      end
      PARITY: if (i_baud) state_n = STOP;
      STOP: if (i_baud) begin
        if (stop2 && !stop_cnt) stop_cnt_n = 1'b1;
        else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // line level is registered from the next state so it changes with the state
    tx_n = state_n == START ? 1'b0
         : state_n == DATA ? shift_n[0]
         : state_n == PARITY ? par_n : 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      shift     <= '0;
      len       <= LEN_W'(5);
      bit_cnt   <= '0;
      par       <= 1'b0;
      has_par   <= 1'b0;
      stop2     <= 1'b0;
      stop_cnt  <= 1'b0;
      o_TX      <= 1'b1;
      o_baud_en <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      len       <= len_n;
      bit_cnt   <= bit_cnt_n;
      par       <= par_n;
      has_par   <= has_par_n;
      stop2     <= stop2_n;
      stop_cnt  <= stop_cnt_n;
      o_TX      <= tx_n;
      o_baud_en <= state_n != IDLE;
      o_busy    <= state_n != IDLE || count_n != '0;
    end
  end
endmodule
